// File: rtl/ysyx_25070198_bus_pkg.sv
// Shared SimpleBus types, constants and the pmem access hooks used by the SRAM responder.
// The pmem hooks are a simulation-only in-package memory model with call bookkeeping.
package ysyx_25070198_bus_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   localparam int DATA_W = 32;
   localparam int MASK_W = 4;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Taps 8,6,5,4 of the x^8 register land on bits 7,5,4,3.
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

   int  pmem_mem [int];
   int  pmem_read_calls;
   int  pmem_write_calls;
   int  pmem_last_raddr;
   int  pmem_last_waddr;
   int  pmem_last_wdata;
   byte pmem_last_wmask;

   // Unwritten locations read as zero.
   function automatic int pmem_read(input int raddr);
      pmem_read_calls++;
      pmem_last_raddr = raddr;
      return pmem_mem.exists(raddr) ? pmem_mem[raddr] : 0;
   endfunction

   // Byte-masked merge into the stored word, with call bookkeeping for the bench.
   function automatic void pmem_write(input int waddr, input int wdata, input byte wmask);
      int word;
      word = pmem_mem.exists(waddr) ? pmem_mem[waddr] : 0;
      for (int i = 0; i < 4; i++) begin
         if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
      end
      pmem_mem[waddr]  = word;
      pmem_write_calls++;
      pmem_last_waddr = waddr;
      pmem_last_wdata = wdata;
      pmem_last_wmask = wmask;
   endfunction

endpackage

// File: rtl/ysyx_25070198_lfsr8.sv
// 8-bit Fibonacci LFSR (seed 8'hA5) that supplies the extra random wait cycles.
// Only present when SRAM_RAND_DELAY_EN is defined, the only build that instantiates it.
`ifdef SRAM_RAND_DELAY_EN
module ysyx_25070198_lfsr8
    import ysyx_25070198_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule
`endif

// File: rtl/ysyx_25070198_sram.sv
// SimpleBus memory responder: accepts one request, waits LATENCY cycles, accesses pmem, then responds.
// Defining SRAM_RAND_DELAY_EN adds 0..7 pseudo-random wait cycles per request.
module ysyx_25070198_sram
    import ysyx_25070198_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata
);

`ifdef SRAM_RAND_DELAY_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("ysyx_25070198_sram: LATENCY must be within 1..15");
    end
    if (DATA_W != ysyx_25070198_bus_pkg::DATA_W) begin : g_bad_data_w
        $error("ysyx_25070198_sram: DATA_W must be 32");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_load;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              access;
    logic              addr_unused;

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;
    logic       lfsr_unused;

    ysyx_25070198_lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (lfsr_q)
    );

    assign cnt_load    = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[2:0]);
    assign lfsr_unused = ^lfsr_q[7:3];
`else
    assign cnt_load = CNT_W'(LATENCY - 1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = cnt_load;
                    addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                    rdata_d = '0;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The pmem call has side effects, so it happens exactly once, at the clock edge that ends WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            if (access) begin
                if (!wen_q) begin
                    rdata_q <= DATA_W'(pmem_read(int'(addr_q)));
                end else if (wmask_q != '0) begin
                    pmem_write(int'(addr_q), int'(wdata_q), byte'({4'b0000, wmask_q}));
                end
            end
        end
    end

    assign req_ready   = rst && (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = rdata_q;
    assign addr_unused = ^req_addr[1:0];

endmodule

// File: tb/tb_ysyx_25070198_sram.sv
// Self-checking bench for ysyx_25070198_sram: vector table, held-response and mid-reset sequences,
// and a random run checked against a shadow memory. Expected read data travels through a scoreboard queue.
module tb_ysyx_25070198_sram;

    localparam int LAT = 3;
`ifdef SRAM_RAND_DELAY_EN
    localparam int EXTRA_MAX = 7;
`else
    localparam int EXTRA_MAX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    ysyx_25070198_sram #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] exp_q [$];
    logic [31:0] shadow [logic [31:0]];
    int          tests_run;
    int          failures;
    int          issued;
    int          responses;
    int          lat_min;
    int          lat_max;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        tests_run++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // One complete transaction: drive, time the response, check data, hold, handshake and pmem call log.
    task automatic applyStimulus(input string tag, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wmask,
                                 input logic [31:0] exp_rdata, input int hold);
        int          n;
        int          wr_before;
        int          rd_before;
        bit          saw_ready;
        logic [31:0] exp;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checkOutput({tag, " ready_timeout"}, 32'(req_ready), 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wmask  = wmask;
        resp_ready = (hold == 0);
        exp_q.push_back(exp_rdata);
        issued++;
        wr_before = ysyx_25070198_bus_pkg::pmem_write_calls;
        rd_before = ysyx_25070198_bus_pkg::pmem_read_calls;
        @(posedge clk);
        #1;
        // Scramble the request lines: only the accept edge may matter.
        req_valid = 1'b0;
        req_wen   = ~wen;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wmask = 4'($urandom_range(0, 15));
        n = 0;
        saw_ready = 1'b0;
        while (!resp_valid && n < LAT + EXTRA_MAX + 20) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready) saw_ready = 1'b1;
        end
        if (!resp_valid) begin
            checkOutput({tag, " resp_timeout"}, 32'(resp_valid), 32'd1);
            void'(exp_q.pop_front());
            resp_ready = 1'b0;
            return;
        end
        responses++;
        if (n < lat_min) lat_min = n;
        if (n > lat_max) lat_max = n;
        checkRange({tag, " latency"}, n, LAT, LAT + EXTRA_MAX);
        checkOutput({tag, " busy_req_ready"}, 32'(saw_ready), 32'd0);
        exp = exp_q.pop_front();
        checkOutput({tag, " rdata"}, resp_rdata, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
            checkOutput({tag, " hold_rdata"}, resp_rdata, exp);
            checkOutput({tag, " hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        if (hold > 0) begin
            @(negedge clk);
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput({tag, " valid_after_hs"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, " idle_after_hs"}, 32'(req_ready), 32'd1);
        if (wen) begin
            checkOutput({tag, " write_calls"},
                        32'(ysyx_25070198_bus_pkg::pmem_write_calls - wr_before),
                        (wmask != 4'b0) ? 32'd1 : 32'd0);
            if (wmask != 4'b0) begin
                checkOutput({tag, " waddr"}, ysyx_25070198_bus_pkg::pmem_last_waddr, {addr[31:2], 2'b00});
                checkOutput({tag, " wdata"}, ysyx_25070198_bus_pkg::pmem_last_wdata, wdata);
                checkOutput({tag, " wmask"}, {24'b0, ysyx_25070198_bus_pkg::pmem_last_wmask}, {28'b0, wmask});
            end
        end else begin
            checkOutput({tag, " read_calls"},
                        32'(ysyx_25070198_bus_pkg::pmem_read_calls - rd_before), 32'd1);
            checkOutput({tag, " raddr"}, ysyx_25070198_bus_pkg::pmem_last_raddr, {addr[31:2], 2'b00});
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wr_before;
        tests_run  = 0;
        failures   = 0;
        issued     = 0;
        responses  = 0;
        lat_min    = 1000;
        lat_max    = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        resp_ready = 1'b0;

        vecs[0]  = '{1'b1, 32'h8000_0000, 32'h0010_0093, 4'hF,    32'h0};
        vecs[1]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0,    32'h0010_0093};
        vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF,    32'h0};
        vecs[3]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 32'h0};
        vecs[4]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'h1122_BEEF};
        vecs[5]  = '{1'b0, 32'h8000_0012, 32'h0,         4'h0,    32'h1122_BEEF};
        vecs[6]  = '{1'b1, 32'h8000_0004, 32'hCAFE_F00D, 4'hF,    32'h0};
        vecs[7]  = '{1'b0, 32'h8000_0006, 32'h0,         4'h0,    32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0,    32'h0};
        vecs[9]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'h1122_BEEF};
        vecs[10] = '{1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 4'b1100, 32'h0};
        vecs[11] = '{1'b0, 32'h8000_0008, 32'h0,         4'h0,    32'hA5A5_0000};
        vecs[12] = '{1'b0, 32'h8000_0100, 32'h0,         4'h0,    32'h0};

        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset resp_rdata", resp_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_reset req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].wen, vecs[i].addr, vecs[i].wdata,
                          vecs[i].wmask, vecs[i].exp_rdata, 0);
        end

        // Response held back for 10 cycles: data must stay put and no new request may be taken.
        applyStimulus("hold10", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0010_0093, 10);

        // Reset during WAIT of a write: the write must never reach memory.
        @(negedge clk);
        wr_before = ysyx_25070198_bus_pkg::pmem_write_calls;
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wdata = 32'h1234_5678;
        req_wmask = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_wait resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("in_reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("in_reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("in_reset resp_rdata", resp_rdata, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_release req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_release resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_release resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_abandoned write_calls",
                    32'(ysyx_25070198_bus_pkg::pmem_write_calls - wr_before), 32'd0);
        applyStimulus("rst_readback", 1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h0, 0);

        // Random traffic in a fresh region, checked against the bench's own shadow memory.
        lat_min = 1000;
        lat_max = 0;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            logic [31:0] al;
            logic [31:0] wd;
            logic [31:0] word;
            logic [3:0]  wm;
            logic        w;
            a    = 32'h8000_1000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            al   = {a[31:2], 2'b00};
            w    = 1'($urandom_range(0, 1));
            wd   = $urandom;
            wm   = 4'($urandom_range(0, 15));
            word = shadow.exists(al) ? shadow[al] : 32'h0;
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (wm[b]) word[8*b +: 8] = wd[8*b +: 8];
                end
                shadow[al] = word;
                word       = 32'h0;
            end
            applyStimulus($sformatf("rand%0d", i), w, a, wd, wm, word, $urandom_range(0, 2));
        end

`ifdef SRAM_RAND_DELAY_EN
        checkOutput("rand lat_min", 32'(lat_min), 32'(LAT));
        checkOutput("rand lat_max", 32'(lat_max), 32'(LAT + 7));
`endif
        checkOutput("responses", 32'(responses), 32'(issued));
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
